fxp_requant_pipe: RTL
=====================

// Module: fxp_requant_pipe
// PURPOSE
//  Multi-lane pipelined requantiser: scales wide signed accumulators by an integer multiplier,
//  shifts right with selectable rounding, adds a zero point and saturates to OUT_W bits.
//  Sits between the MAC array accumulators and the activation buffer.
//  Generalises the scalar saturate / round-shift helpers with lanes, rounding modes, signed or
//  unsigned output, valid/ready flow control and saturation statistics.
// PARAMETERS
//  LANES      4   parallel lanes per beat
//  IN_W       32  signed accumulator width per lane
//  MULT_W     16  signed multiplier width
//  SHIFT_W    6   shift amount width; legal shift 0..IN_W+MULT_W-1
//  OUT_W      8   output width per lane
//  OUT_SIGNED 1   1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; 0: clamp to [0, 2^OUT_W-1]
//  CNT_W      16  saturation counter width
// PORTS
//  clk        in   1             sole clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  in_valid   in   1             input beat valid
//  in_ready   out  1             block can accept a beat
//  in_acc     in   LANES*IN_W    lane i in bits [i*IN_W +: IN_W], signed
//  in_mult    in   MULT_W        signed multiplier, shared by all lanes of the beat
//  in_shift   in   SHIFT_W       unsigned right-shift amount
//  in_zp      in   OUT_W         zero point; signed if OUT_SIGNED=1, else unsigned
//  in_rmode   in   2             0 truncate (floor), 1 half-up, 2 half-to-even, 3 = same as 1
//  out_valid  out  1             output beat valid
//  out_ready  in   1             downstream accepts the beat
//  out_data   out  LANES*OUT_W   requantised lanes, same packing as in_acc
//  out_sat    out  LANES         per-lane flag: value was clamped
//  sat_clr    in   1             synchronous clear of sat_count
//  sat_count  out  CNT_W         total clamped lanes since reset or clear; sticks at all-ones
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_data, out_sat and sat_count go to 0. in_ready is 1
//   after reset.
//  Pipeline: 3 registered stages. S1 = product. S2 = round/shift. S3 = zero point + saturate.
//   S3 is the output register. Latency is 3 cycles from the accept edge to out_valid, with no stall.
//  Config (mult, shift, zp, rmode) is captured with its beat and carries along with the data.
//   Beats may change config on every transfer.
//  Flow control: en = !out_valid || out_ready. All stages advance only when en is 1.
//   in_ready = en, combinational.
//   Accept = in_valid && in_ready. Bubbles travel as invalid stages.
//   While out_valid && !out_ready: out_data and out_sat hold stable and no stage changes.
//  S1: p = in_acc * in_mult as a full signed product, PW = IN_W+MULT_W bits.
//  S2: with S = shift, computed in PW+1 bits so the rounding add cannot overflow:
//   S = 0 -> q = p, in every mode.
//   mode 0 -> q = p >>> S (floor).
//   mode 1 -> q = (p + 2^(S-1)) >>> S.
//   mode 2 -> q = p >>> S, then r = p[S-1:0] and h = 2^(S-1);
//             q += 1 if r > h, or if r == h and q[0] == 1.
//  S3: v = q + zp, sign- or zero-extended per OUT_SIGNED, with no intermediate wrap.
//   If v is out of range it is clamped to the nearest bound and out_sat[i] = 1.
//   Otherwise out = v[OUT_W-1:0] and out_sat[i] = 0.
//  sat_count: on each output transfer (out_valid && out_ready) it adds popcount(out_sat).
//   The add saturates at 2^CNT_W-1.
//   If sat_clr and a transfer happen in the same cycle, sat_clr wins and the count becomes 0.
//  Reset asserted mid-operation flushes all in-flight beats immediately. No partial beat is
//   ever emitted.
//  in_shift >= PW is out of contract; the implementation clamps S to PW-1.
// TESTING
//  1 LANES=4, mult=1, shift=3, acc={100,-20,104,-4}, rmode=0
//    -> {12,-3,13,-1}; latency exactly 3 cycles.
//  2 same acc, rmode=1 -> {13,-2,13,0}; rmode=2 -> {12,-2,13,0}
//    (checks 12.5->12 and -2.5->-2 tie cases).
//  3 acc={1000,-1000,127,-128}, mult=1, shift=0, zp=0, OUT_SIGNED=1
//    -> {127,-128,127,-128}, out_sat=4'b0011, sat_count +2.
//  4 OUT_SIGNED=0, zp=128, acc={-200,0,200,-128}, mult=1, shift=0
//    -> {0,128,255,0}, out_sat=4'b0101.
//  5 Back-to-back beats 1..6 with out_ready held low for 5 cycles after the first output
//    -> in_ready drops once 3 beats are in flight, out_data stays stable,
//       all 6 beats arrive in order with none lost or duplicated.
//  6 Preload sat_count to all-ones via saturating traffic, then add more -> stays all-ones.
//    Pulse sat_clr together with a transfer -> 0.
//    Assert rst with 2 beats in flight -> out_valid=0 at once, in_ready=1 after release.

Source files
------------

// File: rtl/fxp_requant_pipe.sv
// Multi-lane requantiser: acc*mult, rounding right shift, zero point add, clamp to OUT_W bits.
// Latency: 3 register stages (product, round/shift, zero point + clamp); one beat per cycle.
// Backpressure: whole pipe stalls while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module fxp_requant_pipe #(
  parameter int LANES      = 4,
  parameter int IN_W       = 32,
  parameter int MULT_W     = 16,
  parameter int SHIFT_W    = 6,
  parameter int OUT_W      = 8,
  parameter bit OUT_SIGNED = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_acc,
  input  logic [MULT_W-1:0]      in_mult,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic [OUT_W-1:0]       in_zp,
  input  logic [1:0]             in_rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  // Product width, rounding width (one guard bit so the half add never overflows),
  // and zero-point sum width (one more bit so q + zp never wraps).
  localparam int PW = IN_W + MULT_W;
  localparam int QW = PW + 1;
  localparam int VW = PW + 2;

  // Largest meaningful shift; anything above behaves as this.
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(PW - 1);

  // Output clamp bounds in the zero-point sum domain.
  localparam logic signed [VW-1:0] OUT_HI = OUT_SIGNED ? ((VW'(1) <<< (OUT_W - 1)) - VW'(1))
                                                       : ((VW'(1) <<< OUT_W) - VW'(1));
  localparam logic signed [VW-1:0] OUT_LO = OUT_SIGNED ? -(OUT_HI + VW'(1)) : VW'(0);
  localparam logic [OUT_W-1:0]     OUT_HI_W = OUT_HI[OUT_W-1:0];
  localparam logic [OUT_W-1:0]     OUT_LO_W = OUT_LO[OUT_W-1:0];

  // Per-beat configuration that travels alongside the data.
  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic [OUT_W-1:0]   zp;
    logic [1:0]         rmode;
  } cfg_t;

  // Out-of-range shifts collapse onto the largest legal shift.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] r;
    if (s > SHIFT_MAX) r = SHIFT_MAX;
    else               r = s;
    return r;
  endfunction

  // Arithmetic right shift with rounding: 0 floor, 1/3 half-up, 2 half-to-even.
  function automatic logic signed [QW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                       input logic [SHIFT_W-1:0]   s,
                                                       input logic [1:0]           mode);
    logic signed [QW-1:0] pe;
    logic signed [QW-1:0] fl;
    logic signed [QW-1:0] up;
    logic signed [QW-1:0] res;
    logic [QW-1:0]        half;
    logic [QW-1:0]        mask;
    logic [QW-1:0]        rem;
    logic                 bump;
    pe   = QW'(p);
    half = (s == '0) ? '0 : (QW'(1) << (s - SHIFT_W'(1)));
    mask = (QW'(1) << s) - QW'(1);
    rem  = pe & mask;
    fl   = pe >>> s;
    up   = (pe + $signed(half)) >>> s;
    // Exact tie rounds toward the even quotient; above half always rounds up.
    bump = (rem > half) || ((rem == half) && fl[0]);
    if (s == '0) begin
      res = pe;
    end else begin
      case (mode)
        2'd0:    res = fl;
        2'd2:    res = fl + QW'(bump);
        default: res = up;
      endcase
    end
    return res;
  endfunction

  // Adds the zero point in a non-wrapping width and clamps; returns {sat, value}.
  function automatic logic [OUT_W:0] zp_clamp(input logic signed [QW-1:0] q,
                                              input logic [OUT_W-1:0]     zp);
    logic signed [VW-1:0] zpe;
    logic signed [VW-1:0] v;
    logic [OUT_W:0]       res;
    if (OUT_SIGNED) zpe = VW'($signed(zp));
    else            zpe = VW'(zp);
    v = VW'(q) + zpe;
    if (v > OUT_HI)      res = {1'b1, OUT_HI_W};
    else if (v < OUT_LO) res = {1'b1, OUT_LO_W};
    else                 res = {1'b0, v[OUT_W-1:0]};
    return res;
  endfunction

  // Global advance enable shared by every stage.
  logic en;
  logic accept;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  cfg_t in_cfg;
  assign in_cfg = '{shift: in_shift, zp: in_zp, rmode: in_rmode};

  // ---------------- Stage 1: full signed product ----------------
  logic                 s1_valid;
  cfg_t                 s1_cfg;
  logic signed [PW-1:0] s1_prod [LANES];
  logic signed [PW-1:0] prod    [LANES];

  // Sign-extend both operands to the product width before multiplying.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PW'($signed(in_acc[i*IN_W +: IN_W])) * PW'($signed(in_mult));
    end
  end

  // Stage 1 register: capture product and config on accept, bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cfg   <= '0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_cfg <= in_cfg;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
      end
    end
  end

  // ---------------- Stage 2: rounding right shift ----------------
  logic                 s2_valid;
  logic [OUT_W-1:0]     s2_zp;
  logic signed [QW-1:0] s2_q    [LANES];
  logic signed [QW-1:0] q_next  [LANES];
  logic [SHIFT_W-1:0]   s1_shift_eff;

  assign s1_shift_eff = clamp_shift(s1_cfg.shift);

  // Round/shift every lane with the beat's own shift and mode.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      q_next[i] = round_shift(s1_prod[i], s1_shift_eff, s1_cfg.rmode);
    end
  end

  // Stage 2 register: quotient plus the zero point still needed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_zp    <= '0;
      for (int i = 0; i < LANES; i++) s2_q[i] <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_zp <= s1_cfg.zp;
        for (int i = 0; i < LANES; i++) s2_q[i] <= q_next[i];
      end
    end
  end

  // ---------------- Stage 3: zero point + saturate (output) ----------------
  logic [LANES*OUT_W-1:0] data_next;
  logic [LANES-1:0]       sat_next;

  // Clamp each lane and flag the ones that hit a bound.
  always_comb begin
    data_next = '0;
    sat_next  = '0;
    for (int i = 0; i < LANES; i++) begin
      {sat_next[i], data_next[i*OUT_W +: OUT_W]} = zp_clamp(s2_q[i], s2_zp);
    end
  end

  // Output register: holds its contents whenever the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= data_next;
        out_sat  <= sat_next;
      end
    end
  end

  // ---------------- Saturation statistics ----------------
  logic [CNT_W:0] sat_sum;

  // Count plus clamped lanes of the current beat, one spare bit to detect overflow.
  always_comb begin
    sat_sum = {1'b0, sat_count};
    for (int i = 0; i < LANES; i++) begin
      sat_sum = sat_sum + (CNT_W + 1)'(out_sat[i]);
    end
  end

  // Accumulate on each transfer, sticking at all-ones; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

endmodule
